// File: rtl/chal_store.sv
// Challenge byte store: loads up to C_DEPTH bytes through a valid/ready write port
// and serves zero-latency reads gated by the number of bytes written.
module chal_store #(
    parameter int unsigned C_MEMDATAWIDTH = 8,
    parameter int unsigned C_MEMADDRWIDTH = 24,
    parameter int unsigned C_DEPTHLOG     = 6
) (
    input  logic                      I_sclk,
    input  logic                      I_rst,
    input  logic                      I_load_start,
    input  logic                      I_load_end,
    input  logic                      I_wr_valid,
    input  logic [C_MEMDATAWIDTH-1:0] I_wr_data,
    output logic                      O_wr_ready,
    input  logic [C_MEMADDRWIDTH-1:0] I_mem_addr,
    output logic [C_MEMDATAWIDTH-1:0] O_mem_data,
    output logic                      O_loaded,
    output logic [C_DEPTHLOG:0]       O_count,
    output logic [C_MEMDATAWIDTH-1:0] O_chksum,
    output logic                      O_err
);

    localparam int unsigned C_DEPTH = 2 ** C_DEPTHLOG;
    localparam int unsigned CW      = C_DEPTHLOG + 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic                      w_ready;
    logic                      w_loaded;
    logic                      w_wr_acc;
    logic                      w_last;
    logic                      w_rd_ok;
    logic [CW-1:0]             r_count;
    logic [C_MEMDATAWIDTH-1:0] r_chksum;
    logic                      r_err;
    logic [C_MEMDATAWIDTH-1:0] r_mem [C_DEPTH];

    // The count doubles as the write pointer; it never wraps.
    assign w_wr_acc = I_wr_valid & w_ready & ~I_load_start;
    assign w_last   = (r_count == CW'(C_DEPTH - 1));

    always_ff @(posedge I_sclk or posedge I_rst) begin
        if (I_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_loaded    = 1'b0;
        case (r_state)
            ST_LOAD: w_ready  = 1'b1;
            ST_FULL: w_loaded = 1'b1;
            ST_DONE: w_loaded = 1'b1;
            default: ;
        endcase
        if (I_load_start) begin
            w_state_nxt = ST_LOAD;
        end else if (r_state == ST_LOAD) begin
            if (I_wr_valid && w_last) begin
                w_state_nxt = ST_FULL;
            end else if (I_load_end) begin
                w_state_nxt = ST_DONE;
            end
        end
    end

    // Load start wins over any write or close arriving in the same cycle.
    always_ff @(posedge I_sclk or posedge I_rst) begin
        if (I_rst) begin
            r_count  <= '0;
            r_chksum <= '0;
            r_err    <= 1'b0;
            for (int unsigned i = 0; i < C_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (I_load_start) begin
            r_count  <= '0;
            r_chksum <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_mem[r_count[C_DEPTHLOG-1:0]] <= I_wr_data;
                r_count                        <= r_count + CW'(1);
                r_chksum                       <= r_chksum ^ I_wr_data;
            end
            if (I_wr_valid && !w_ready) begin
                r_err <= 1'b1;
            end
        end
    end

    assign w_rd_ok = (I_mem_addr < C_MEMADDRWIDTH'(C_DEPTH)) &&
                     (I_mem_addr < C_MEMADDRWIDTH'(r_count));

    assign O_mem_data = w_rd_ok ? r_mem[I_mem_addr[C_DEPTHLOG-1:0]] : '0;
    assign O_wr_ready = w_ready;
    assign O_loaded   = w_loaded;
    assign O_count    = r_count;
    assign O_chksum   = r_chksum;
    assign O_err      = r_err;

endmodule

// File: tb/tb_chal_store.sv
// Random and directed stimulus for chal_store, checked each cycle against a
// behavioural model of the load/read rules.
module tb_chal_store;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_start = 1'b0;
    logic        ld_end = 1'b0;
    logic        wv = 1'b0;
    logic [7:0]  wd = '0;
    logic [23:0] addr = '0;
    logic        wr_ready;
    logic [7:0]  mem_data;
    logic        loaded;
    logic [6:0]  count;
    logic [7:0]  chksum;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Behavioural model
    int         m_cnt = 0;
    logic [7:0] m_chk = '0;
    bit         m_err = 1'b0;
    bit         m_acc = 1'b0;
    bit         m_loaded = 1'b0;
    logic [7:0] m_mem [64];

    chal_store dut (
        .I_sclk       (clk),
        .I_rst        (rst),
        .I_load_start (ld_start),
        .I_load_end   (ld_end),
        .I_wr_valid   (wv),
        .I_wr_data    (wd),
        .O_wr_ready   (wr_ready),
        .I_mem_addr   (addr),
        .O_mem_data   (mem_data),
        .O_loaded     (loaded),
        .O_count      (count),
        .O_chksum     (chksum),
        .O_err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: a load accepts bytes until it is closed or 64 bytes are held.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= 0; m_chk <= '0; m_err <= 1'b0; m_acc <= 1'b0; m_loaded <= 1'b0;
            for (int i = 0; i < 64; i++) m_mem[i] <= '0;
        end else if (ld_start) begin
            m_cnt <= 0; m_chk <= '0; m_err <= 1'b0; m_acc <= 1'b1; m_loaded <= 1'b0;
        end else if (m_acc) begin
            if (wv) begin
                m_mem[m_cnt] <= wd;
                m_cnt        <= m_cnt + 1;
                m_chk        <= m_chk ^ wd;
                if (m_cnt == 63) begin
                    m_acc <= 1'b0; m_loaded <= 1'b1;
                end
            end
            if (ld_end) begin
                m_acc <= 1'b0; m_loaded <= 1'b1;
            end
        end else if (wv) begin
            m_err <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wr_ready", 32'(wr_ready), 32'(m_acc));
            chk("loaded",   32'(loaded),   32'(m_loaded));
            chk("count",    32'(count),    32'(m_cnt));
            chk("chksum",   32'(chksum),   32'(m_chk));
            chk("err",      32'(err),      32'(m_err));
            chk("mem_data", 32'(mem_data),
                (32'(addr) < 32'(m_cnt)) ? 32'(m_mem[addr[5:0]]) : 32'd0);
        end
    end

    task automatic cyc(input bit st, input bit en, input bit v, input logic [7:0] d,
                       input logic [23:0] a);
        ld_start = st; ld_end = en; wv = v; wd = d; addr = a;
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        ld_start = 1'b0; ld_end = 1'b0; wv = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        quiet();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        do_reset();
        cmp_en = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(wr_ready), 32'd0);

        // Three-byte load
        cyc(1, 0, 0, 8'h00, 24'd0);
        cyc(0, 0, 1, 8'h03, 24'd0);
        cyc(0, 0, 1, 8'h11, 24'd0);
        cyc(0, 0, 1, 8'h2A, 24'd0);
        cyc(0, 1, 0, 8'h00, 24'd0);
        quiet();
        addr = 24'd1; #1;
        chk("lit_rd1", 32'(mem_data), 32'h11);
        chk("lit_count3", 32'(count), 32'd3);
        chk("lit_chk38", 32'(chksum), 32'h38);
        chk("lit_loaded", 32'(loaded), 32'd1);
        addr = 24'd3; #1;
        chk("lit_rd3", 32'(mem_data), 32'h0);

        // Zero-latency address stepping
        @(posedge clk); #1;
        addr = 24'd0; #1; chk("step0", 32'(mem_data), 32'h03);
        @(posedge clk); #1;
        addr = 24'd1; #1; chk("step1", 32'(mem_data), 32'h11);
        @(posedge clk); #1;
        addr = 24'd2; #1; chk("step2", 32'(mem_data), 32'h2A);

        // Fill to 64 entries, then one more write
        cyc(1, 0, 0, 8'h00, 24'd0);
        for (int i = 0; i < 64; i++) cyc(0, 0, 1, 8'(i + 1), 24'(i));
        chk("full_count", 32'(count), 32'd64);
        chk("full_ready", 32'(wr_ready), 32'd0);
        chk("full_loaded", 32'(loaded), 32'd1);
        chk("full_err0", 32'(err), 32'd0);
        cyc(0, 0, 1, 8'hFF, 24'd63);
        chk("full_err1", 32'(err), 32'd1);
        chk("full_count2", 32'(count), 32'd64);
        chk("full_rd63", 32'(mem_data), 32'd64);

        // Write in idle sets error; start clears it
        do_reset();
        cyc(0, 0, 1, 8'h12, 24'd0);
        chk("idle_err", 32'(err), 32'd1);
        cyc(1, 0, 0, 8'h00, 24'd0);
        chk("start_clr_err", 32'(err), 32'd0);

        // Start with a simultaneous write drops the byte
        cyc(0, 0, 1, 8'hAA, 24'd0);
        cyc(0, 1, 0, 8'h00, 24'd0);
        cyc(1, 0, 1, 8'h55, 24'd0);
        chk("prio_count", 32'(count), 32'd0);
        chk("prio_err", 32'(err), 32'd0);
        chk("prio_ready", 32'(wr_ready), 32'd1);
        cyc(0, 1, 1, 8'h66, 24'd0);
        chk("end_wr_count", 32'(count), 32'd1);
        chk("end_wr_rd0", 32'(mem_data), 32'h66);

        // Asynchronous reset mid-load
        cyc(1, 0, 0, 8'h00, 24'd0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'(8'h90 + i), 24'd2);
        quiet();
        rst = 1'b1; #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_chk", 32'(chksum), 32'd0);
        chk("arst_ready", 32'(wr_ready), 32'd0);
        chk("arst_rd", 32'(mem_data), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            addr = 24'(i); #1;
            chk("arst_rd_after", 32'(mem_data), 32'd0);
        end

        // Randomized traffic with occasional resets
        for (int n = 0; n < 4000; n++) begin
            logic [23:0] a;
            a = ($urandom_range(0, 9) == 0) ? 24'($urandom) : 24'($urandom_range(0, 70));
            rst = ($urandom_range(0, 599) == 0);
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 49) == 0,
                $urandom_range(0, 9) < 6, 8'($urandom), a);
        end
        rst = 1'b0;
        quiet();
        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
